// File: rtl/inst_fetch_responder_if.sv
// Fetch-side and memory read-channel signals shared by the PrePc requester,
// the fetch responder and the SoC bus.
interface inst_fetch_responder_if #(
   parameter int ADDR_W = 64,
   parameter int BUS_W  = 64,
   parameter int DATA_W = 32
);
   logic              FetchReady;
   logic [ADDR_W-1:0] FetchAddr;
   logic              ReadShakeHands;
   logic [DATA_W-1:0] InstOut;
   logic [ADDR_W-1:0] InstAddrOut;
   logic              FetchErr;
   logic              Busy;
   logic              MemArValid;
   logic              MemArReady;
   logic [ADDR_W-1:0] MemAraddr;
   logic              MemRValid;
   logic              MemRReady;
   logic [BUS_W-1:0]  MemRData;
   logic [1:0]        MemRResp;

   modport slave (
      input  FetchReady, FetchAddr, MemArReady, MemRValid, MemRData, MemRResp,
      output ReadShakeHands, InstOut, InstAddrOut, FetchErr, Busy,
             MemArValid, MemAraddr, MemRReady
   );

   modport master (
      output FetchReady, FetchAddr, MemArReady, MemRValid, MemRData, MemRResp,
      input  ReadShakeHands, InstOut, InstAddrOut, FetchErr, Busy,
             MemArValid, MemAraddr, MemRReady
   );
endinterface

// File: rtl/inst_fetch_responder.sv
// Single-outstanding instruction fetch responder: one AR/R read per request,
// result returned to the IFU with a one-cycle ReadShakeHands pulse.
module inst_fetch_responder #(
   parameter int              ADDR_W   = 64,
   parameter int              BUS_W    = 64,
   parameter int              DATA_W   = 32,
   parameter int              TIMEOUT  = 255,
   parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
   input logic                  Clk,
   input logic                  Rst,
   inst_fetch_responder_if.slave bus
);

   localparam int         LANES   = BUS_W / 32;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                drain_pend_q, drain_pend_d;
   logic                ar_valid_q, ar_valid_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                r_ready_q, r_ready_d;
   logic                shake_q, shake_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
   logic                busy_q, busy_d;

   function automatic logic [DATA_W-1:0] lane_sel(input logic [BUS_W-1:0]  d,
                                                   input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = d[DATA_W-1:0];
      for (int i = 1; i < LANES; i++)
         if (((a >> 2) & ADDR_W'(LANES - 1)) == ADDR_W'(i)) r = d[32*i +: DATA_W];
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] bus_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(BUS_W/8 - 1);
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      drain_pend_d = drain_pend_q;
      ar_valid_d   = 1'b0;
      araddr_d     = araddr_q;
      r_ready_d    = 1'b0;
      shake_d      = 1'b0;
      err_d        = 1'b0;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;

      // Outputs are registered, so each branch sets the values the next state presents.
      unique case (state_q)
         IDLE: begin
            if (bus.FetchReady) begin
               addr_d       = bus.FetchAddr;
               cnt_d        = 8'd0;
               drain_pend_d = 1'b0;
               if (bus.FetchAddr[1:0] != 2'b00) begin
                  state_d     = RESP;
                  shake_d     = 1'b1;
                  err_d       = 1'b1;
                  inst_d      = NOP_INST[DATA_W-1:0];
                  inst_addr_d = bus.FetchAddr;
               end else begin
                  state_d    = ADDR;
                  ar_valid_d = 1'b1;
                  araddr_d   = bus_align(bus.FetchAddr);
               end
            end
         end
         ADDR: begin
            cnt_d = cnt_q + 8'd1;
            if (bus.MemArReady) begin
               state_d   = DATA;
               r_ready_d = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               // Address never accepted: nothing in flight, so no drain needed.
               state_d     = RESP;
               shake_d     = 1'b1;
               err_d       = 1'b1;
               inst_d      = NOP_INST[DATA_W-1:0];
               inst_addr_d = addr_q;
            end else begin
               ar_valid_d = 1'b1;
            end
         end
         DATA: begin
            cnt_d = cnt_q + 8'd1;
            if (bus.MemRValid) begin
               state_d     = RESP;
               shake_d     = 1'b1;
               err_d       = (bus.MemRResp != 2'b00);
               inst_d      = (bus.MemRResp != 2'b00) ? NOP_INST[DATA_W-1:0]
                                                     : lane_sel(bus.MemRData, addr_q);
               inst_addr_d = addr_q;
            end else if (cnt_q == TO_LAST) begin
               state_d      = RESP;
               shake_d      = 1'b1;
               err_d        = 1'b1;
               inst_d       = NOP_INST[DATA_W-1:0];
               inst_addr_d  = addr_q;
               drain_pend_d = 1'b1;
            end else begin
               r_ready_d = 1'b1;
            end
         end
         RESP: begin
            state_d   = drain_pend_q ? DRAIN : IDLE;
            r_ready_d = drain_pend_q;
         end
         DRAIN: begin
            // Swallow the late beat of the timed-out read before accepting new work.
            if (bus.MemRValid) state_d = IDLE;
            else               r_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         drain_pend_q <= 1'b0;
         ar_valid_q   <= 1'b0;
         araddr_q     <= '0;
         r_ready_q    <= 1'b0;
         shake_q      <= 1'b0;
         err_q        <= 1'b0;
         inst_q       <= '0;
         inst_addr_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         drain_pend_q <= drain_pend_d;
         ar_valid_q   <= ar_valid_d;
         araddr_q     <= araddr_d;
         r_ready_q    <= r_ready_d;
         shake_q      <= shake_d;
         err_q        <= err_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.MemArValid     = ar_valid_q;
   assign bus.MemAraddr      = araddr_q;
   assign bus.MemRReady      = r_ready_q;
   assign bus.ReadShakeHands = shake_q;
   assign bus.FetchErr       = err_q;
   assign bus.InstOut        = inst_q;
   assign bus.InstAddrOut    = inst_addr_q;
   assign bus.Busy           = busy_q;

endmodule
